adc_sample_sequencer: RTL

- Sequences the external parallel-output ADC once per range cell.
- Converts each qualified ADC launch pulse from the range decoder into a convert-start / busy / read handshake with the ADC.
- Tags each sample with the range code captured at launch and queues it in a small FWFT FIFO for the downstream video processor.
- Sits between range decode and the signal-processing chain; it is the only block that drives ADC control pins.

---
 rtl/adc_sample_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: ADC convst/busy/read handshake with a range-tagged FWFT sample FIFO; optional SECTOR_GATE_EN adds bearing-sector launch gating
module adc_sample_sequencer #(
  parameter int DATA_W        = 12,
  parameter int CONVST_CYCLES = 4,
  parameter int BUSY_TIMEOUT  = 100,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic                          AdcLaunch,
  input  logic                          RangeTrace,
  input  logic [9:0]                    RangeCode,
  output logic                          AdcConvSt,
  input  logic                          AdcBusy,
  output logic                          AdcRd,
  input  logic [DATA_W-1:0]             AdcData,
  output logic                          SampleValid,
  input  logic                          SampleReady,
  output logic [DATA_W-1:0]             SampleData,
  output logic [9:0]                    SampleRange,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
  input  logic                          ClearFlags,
  output logic                          Overflow,
  output logic                          Timeout,
  output logic                          MissedLaunch
`ifdef SECTOR_GATE_EN
  ,
  input  logic [3:0]                    BearSector,
  input  logic [15:0]                   SectorMask
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, CONVST, WAIT_HI, WAIT_LO, READ, PUSH} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic busy_m, busy_s;
  logic [9:0] rng_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [9:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic gate_ok, accept, t_exp;
  logic conv_nx, rd_nx, cnt_clr, to_evt, miss_evt, push;
  logic full, pop, wr_en, ovf_evt;
`ifdef SECTOR_GATE_EN
  assign gate_ok = SectorMask[BearSector];
`else
  assign gate_ok = 1'b1;
`endif
  assign accept = AdcLaunch & RangeTrace & gate_ok;
  assign t_exp = cnt == 8'(BUSY_TIMEOUT - 1);
  assign SampleValid = FifoLevel != '0;
  assign SampleData = SampleValid ? mem_d[rd_ptr] : '0;
  assign SampleRange = SampleValid ? mem_r[rd_ptr] : '0;
  assign full = FifoLevel == LW'(FIFO_DEPTH);
  assign pop = SampleValid & SampleReady;
  assign wr_en = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;
  // next-state: timeout aborts either busy wait back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? CONVST : IDLE;
      CONVST:  state_nx = cnt == 8'(CONVST_CYCLES - 1) ? WAIT_HI : CONVST;
      WAIT_HI: state_nx = busy_s ? WAIT_LO : t_exp ? IDLE : WAIT_HI;
      WAIT_LO: state_nx = !busy_s ? READ : t_exp ? IDLE : WAIT_LO;
      READ:    state_nx = cnt[0] ? PUSH : READ;
      PUSH:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // output decode: strobes are registered from the next state; the counter keeps running from WAIT_HI into WAIT_LO
  always_comb begin
    conv_nx = state_nx == CONVST;
    rd_nx = state_nx == READ;
    cnt_clr = state_nx != state && !(state == WAIT_HI && state_nx == WAIT_LO);
    to_evt = (state == WAIT_HI || state == WAIT_LO) && state_nx == IDLE;
    miss_evt = AdcLaunch && state != IDLE;
    push = state == PUSH;
  end
  // state, sync, capture, FIFO pointers and sticky flags (set beats clear)
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      cnt <= '0;
      busy_m <= 1'b0;
      busy_s <= 1'b0;
      AdcConvSt <= 1'b0;
      AdcRd <= 1'b0;
      rng_q <= '0;
      data_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      FifoLevel <= '0;
      Overflow <= 1'b0;
      Timeout <= 1'b0;
      MissedLaunch <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_clr ? '0 : cnt + 8'd1;
      busy_m <= AdcBusy;
      busy_s <= busy_m;
      AdcConvSt <= conv_nx;
      AdcRd <= rd_nx;
      rng_q <= (state == IDLE && accept) ? RangeCode : rng_q;
      data_q <= (state == READ && cnt[0]) ? AdcData : data_q;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(pop);
      FifoLevel <= FifoLevel + LW'(wr_en) - LW'(pop);
      Overflow <= ovf_evt ? 1'b1 : ClearFlags ? 1'b0 : Overflow;
      Timeout <= to_evt ? 1'b1 : ClearFlags ? 1'b0 : Timeout;
      MissedLaunch <= miss_evt ? 1'b1 : ClearFlags ? 1'b0 : MissedLaunch;
    end
  end
  // sample storage; emptiness is tracked by FifoLevel so no reset is needed
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_d[wr_ptr] <= data_q;
      mem_r[wr_ptr] <= rng_q;
    end
  end
endmodule
